// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared constants, FSM state and decode types for the RAS controller (RAS_CTRL_ALT_LINK_EN adds x5 as link)
package ras_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PRED  = 2'd1,
    ST_GAP   = 2'd2,
    ST_FLUSH = 2'd3
  } ras_state_e;

  typedef struct packed {
    logic call;
    logic ret;
    logic branch;
  } ras_dec_t;

  function automatic logic is_link(input logic [4:0] r);
`ifdef RAS_CTRL_ALT_LINK_EN
    return (r == LINK_X1) || (r == LINK_X5);
`else
    return (r == LINK_X1);
`endif
  endfunction

endpackage

// File: rtl/ras_predecode.sv
// rtl/ras_predecode.sv - combinational call/return/branch classifier for one 32-bit instruction
module ras_predecode
  import ras_pkg::*;
(
  input  logic [31:0] i_instr,
  output ras_dec_t    o_dec
);

  logic [6:0] w_opc;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic       w_rd_link;
  logic       w_rs1_link;
  logic       w_unused;

  assign w_opc      = i_instr[6:0];
  assign w_rd       = i_instr[11:7];
  assign w_rs1      = i_instr[19:15];
  assign w_rd_link  = is_link(w_rd);
  assign w_rs1_link = is_link(w_rs1);
  assign w_unused   = ^{i_instr[31:20], i_instr[14:12]};

  // Link-register hint table: a JALR that writes and reads different links both pops and pushes
  always_comb begin
    o_dec = '0;
    if (w_opc == OPC_JAL) begin
      o_dec.call = w_rd_link;
    end else if (w_opc == OPC_JALR) begin
      if (w_rd_link && !w_rs1_link) begin
        o_dec.call = 1'b1;
      end else if (!w_rd_link && w_rs1_link) begin
        o_dec.ret = 1'b1;
      end else if (w_rd_link && w_rs1_link) begin
        o_dec.call = 1'b1;
        o_dec.ret  = (w_rd != w_rs1);
      end
    end else if (w_opc == OPC_BRANCH) begin
      o_dec.branch = 1'b1;
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - return-address-stack controller: fetch/resolve handshakes, branch counter, RAS strobes (RAS_CTRL_ALT_LINK_EN adds x5 as link)
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int MAX_BRANCHES = 128,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_instr,
  input  logic            resolve_valid,
  output logic            resolve_ready,
  input  logic            resolve_mispredict,
  output logic            ras_push,
  output logic            ras_pop,
  output logic            ras_branch,
  output logic            ras_close_valid,
  output logic            ras_close_invalid,
  output logic [XLEN-1:0] ras_din,
  input  logic [XLEN-1:0] ras_dout,
  input  logic            ras_empty,
  output logic            pred_valid,
  output logic [XLEN-1:0] pred_target,
  output logic            pred_empty,
  output logic            err
);

  localparam int                CNT_W   = $clog2(MAX_BRANCHES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BRANCHES);

  ras_state_e       r_state;
  ras_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_close_prev;
  logic             r_pred_empty;
  logic             r_err;

  ras_dec_t         w_dec;
  logic             w_cnt_full;
  logic             w_cnt_zero;
  logic             w_fetch_ok;
  logic             w_fetch_acc;
  logic             w_res_ok;
  logic             w_res_acc;
  logic             w_close_v;
  logic             w_close_i;

  ras_predecode u_predecode (
    .i_instr (fetch_instr),
    .o_dec   (w_dec)
  );

  assign w_cnt_full = (r_cnt == CNT_MAX);
  assign w_cnt_zero = (r_cnt == '0);

  // Resolve is blocked right after a close so two closes never land on adjacent cycles
  assign w_res_ok  = reset_n && ((r_state == ST_RUN) || (r_state == ST_PRED))
                     && !w_cnt_zero && !r_close_prev;
  assign w_res_acc = resolve_valid && w_res_ok;
  assign w_close_v = w_res_acc && !resolve_mispredict;
  assign w_close_i = w_res_acc && resolve_mispredict;

  // Fetch acceptance and next state; a mispredict wins over everything and flushes
  always_comb begin
    w_fetch_ok  = 1'b0;
    w_state_nxt = ST_RUN;
    case (r_state)
      ST_RUN, ST_GAP: w_fetch_ok = !(w_cnt_full && w_dec.branch) && !w_close_i;
      default:        w_fetch_ok = 1'b0;
    endcase
    w_fetch_ok  = w_fetch_ok && reset_n;
    w_fetch_acc = fetch_valid && w_fetch_ok;
    if (w_close_i) begin
      w_state_nxt = ST_FLUSH;
    end else if (w_fetch_acc && w_dec.ret) begin
      w_state_nxt = ST_PRED;
    end else if (w_close_v) begin
      w_state_nxt = ST_GAP;
    end
  end

  // Outstanding-branch count: saturating by construction since fetch stalls at the limit
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_close_i) begin
      w_cnt_nxt = '0;
    end else if (w_fetch_acc && w_dec.branch && !w_close_v) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (w_close_v && !(w_fetch_acc && w_dec.branch)) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  // State, counter, close history, registered empty flag and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_RUN;
      r_cnt        <= '0;
      r_close_prev <= 1'b0;
      r_pred_empty <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_close_prev <= w_close_v;
      if (ras_pop) begin
        r_pred_empty <= ras_empty;
      end
      if (resolve_valid && w_cnt_zero) begin
        r_err <= 1'b1;
      end
    end
  end

  assign fetch_ready       = w_fetch_ok;
  assign resolve_ready     = w_res_ok;
  assign ras_push          = w_fetch_acc && w_dec.call;
  assign ras_pop           = w_fetch_acc && w_dec.ret;
  assign ras_branch        = w_fetch_acc && w_dec.branch;
  assign ras_close_valid   = w_close_v;
  assign ras_close_invalid = w_close_i;
  assign ras_din           = fetch_pc + XLEN'(4);

  // Top-of-stack data arrives one cycle after the pop, i.e. in the PRED cycle
  assign pred_valid  = (r_state == ST_PRED) && !w_close_i;
  assign pred_empty  = r_pred_empty;
  assign pred_target = (pred_valid && !r_pred_empty) ? ras_dout : '0;
  assign err         = r_err;

endmodule
